// File: rtl/vga_scan_timer.sv
`default_nettype none
// ============================================================================
// Module   : vga_scan_timer
// Purpose  : VGA raster timer with pixel divider, sync/active decode and a
//            flat-colour pixel source.
// Revision : 1.0 - initial release
// ============================================================================
module vga_scan_timer #(
  parameter int          PIX_DIV    = 4,
  parameter int          H_ACTIVE   = 640,
  parameter int          H_FP       = 16,
  parameter int          H_SYNC     = 96,
  parameter int          H_BP       = 48,
  parameter int          V_ACTIVE   = 480,
  parameter int          V_FP       = 10,
  parameter int          V_SYNC     = 2,
  parameter int          V_BP       = 33,
  parameter logic [11:0] DRAW_COLOR = 12'hFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en_counter,
  input  logic        s,
  output logic        f,
  output logic [9:0]  hcount,
  output logic [9:0]  vcount,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic [11:0] rgb
);

  localparam int          c_H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int          c_V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [3:0]  c_DIV_MAX  = 4'(PIX_DIV - 1);
  localparam logic [9:0]  c_H_MAX    = 10'(c_H_TOTAL - 1);
  localparam logic [9:0]  c_V_MAX    = 10'(c_V_TOTAL - 1);
  localparam logic [9:0]  c_H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0]  c_V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0]  c_HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]  c_HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  c_VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  c_VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [3:0]  r_div;
  logic [9:0]  r_hcount;
  logic [9:0]  r_vcount;
  logic        r_hsync;
  logic        r_vsync;
  logic        r_video_on;
  logic [11:0] r_rgb;

  logic        w_pix_tick;
  logic        w_h_last;
  logic        w_v_last;
  logic        w_hs_active;
  logic        w_vs_active;
  logic        w_active;

  assign w_pix_tick = en_counter && (r_div == c_DIV_MAX);
  assign w_h_last   = (r_hcount == c_H_MAX);
  assign w_v_last   = (r_vcount == c_V_MAX);

  // Frame-done marks the cycle whose edge wraps the raster back to (0,0).
  assign f = reset && w_pix_tick && w_h_last && w_v_last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div    <= 4'd0;
      r_hcount <= 10'd0;
      r_vcount <= 10'd0;
    end else if (!en_counter) begin
      r_div    <= 4'd0;
      r_hcount <= 10'd0;
      r_vcount <= 10'd0;
    end else if (w_pix_tick) begin
      r_div <= 4'd0;
      if (w_h_last) begin
        r_hcount <= 10'd0;
        r_vcount <= w_v_last ? 10'd0 : r_vcount + 10'd1;
      end else begin
        r_hcount <= r_hcount + 10'd1;
      end
    end else begin
      r_div <= r_div + 4'd1;
    end
  end

  // Decode is gated by the enable so a dropped scan idles the outputs after one clk.
  assign w_hs_active = en_counter && (r_hcount >= c_HS_START) && (r_hcount < c_HS_END);
  assign w_vs_active = en_counter && (r_vcount >= c_VS_START) && (r_vcount < c_VS_END);
  assign w_active    = en_counter && (r_hcount < c_H_ACT) && (r_vcount < c_V_ACT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hsync    <= 1'b1;
      r_vsync    <= 1'b1;
      r_video_on <= 1'b0;
      r_rgb      <= 12'h000;
    end else begin
      r_hsync    <= !w_hs_active;
      r_vsync    <= !w_vs_active;
      r_video_on <= w_active;
      r_rgb      <= (w_active && !s) ? DRAW_COLOR : 12'h000;
    end
  end

  assign hcount   = r_hcount;
  assign vcount   = r_vcount;
  assign hsync    = r_hsync;
  assign vsync    = r_vsync;
  assign video_on = r_video_on;
  assign rgb      = r_rgb;

endmodule
`default_nettype wire

// File: tb/tb_vga_scan_timer.sv
`default_nettype none
// Directed bench for vga_scan_timer using a shrunken raster:
// 16 px x 10 lines, 2 clk/pixel (main DUT) and 1 clk/pixel (second DUT).
module tb_vga_scan_timer;

  localparam logic [11:0] c_COLOR = 12'hA5C;

  logic        clk;
  logic        reset;
  logic        en_counter;
  logic        s;
  logic        f;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic        hsync;
  logic        vsync;
  logic        video_on;
  logic [11:0] rgb;

  logic        f1;
  logic [9:0]  hcount1;
  logic [9:0]  vcount1;
  logic        hsync1;
  logic        vsync1;
  logic        video_on1;
  logic [11:0] rgb1;

  int checks = 0;
  int errors = 0;

  vga_scan_timer #(
    .PIX_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .DRAW_COLOR(c_COLOR)
  ) u_dut (
    .clk(clk), .reset(reset), .en_counter(en_counter), .s(s), .f(f),
    .hcount(hcount), .vcount(vcount), .hsync(hsync), .vsync(vsync),
    .video_on(video_on), .rgb(rgb)
  );

  vga_scan_timer #(
    .PIX_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .DRAW_COLOR(c_COLOR)
  ) u_dut1 (
    .clk(clk), .reset(reset), .en_counter(en_counter), .s(s), .f(f1),
    .hcount(hcount1), .vcount(vcount1), .hsync(hsync1), .vsync(vsync1),
    .video_on(video_on1), .rgb(rgb1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int hs_low, vs_low, vid, draw, stray, f_cnt, f1_cnt, f1_first, f1_second;

  initial begin
    reset      = 1'b1;
    en_counter = 1'b0;
    s          = 1'b0;
    #1 reset = 1'b0;
    #1;
    check("rst_hcount",   32'(hcount),   32'd0);
    check("rst_vcount",   32'(vcount),   32'd0);
    check("rst_hsync",    32'(hsync),    32'd1);
    check("rst_vsync",    32'(vsync),    32'd1);
    check("rst_video_on", 32'(video_on), 32'd0);
    check("rst_rgb",      32'(rgb),      32'd0);
    check("rst_f",        32'(f),        32'd0);

    step(2);
    reset = 1'b1;
    step(3);
    check("idle_hcount", 32'(hcount), 32'd0);
    check("idle_hsync",  32'(hsync),  32'd1);

    // Frame 1 with s=0: one full frame of counts after enable.
    en_counter = 1'b1;
    hs_low = 0; vs_low = 0; vid = 0; draw = 0; stray = 0;
    f_cnt = 0; f1_cnt = 0; f1_first = 0; f1_second = 0;
    for (int k = 1; k <= 320; k++) begin
      @(posedge clk);
      #1;
      if (!hsync) hs_low++;
      if (!vsync) vs_low++;
      if (video_on) vid++;
      if (video_on && rgb == c_COLOR) draw++;
      if (!video_on && rgb != 12'h000) stray++;
      if (f) f_cnt++;
      if (f1) begin
        f1_cnt++;
        if (f1_cnt == 1) f1_first = k;
        if (f1_cnt == 2) f1_second = k;
      end
      if (k == 1)   check("start_hc_k1", 32'(hcount), 32'd0);
      if (k == 2)   check("start_hc_k2", 32'(hcount), 32'd1);
      if (k == 20)  check("hs_pre_hc", 32'({hcount, 21'd0, hsync}), {10'd10, 21'd0, 1'b1});
      if (k == 21)  check("hs_fall",   32'(hsync), 32'd0);
      if (k == 318) check("f_early",   32'(f), 32'd0);
      if (k == 319) check("f_pulse",   32'({f, hcount, vcount}), 32'({1'b1, 10'd15, 10'd9}));
      if (k == 320) check("wrap_00",   32'({f, hcount, vcount}), 32'd0);
    end
    check("hs_low_clks", 32'(hs_low), 32'd60);
    check("vs_low_clks", 32'(vs_low), 32'd64);
    check("video_clks",  32'(vid),    32'd96);
    check("draw_clks",   32'(draw),   32'd96);
    check("stray_rgb",   32'(stray),  32'd0);
    check("f_count",     32'(f_cnt),  32'd1);
    check("div1_f_cnt",  32'(f1_cnt), 32'd2);
    check("div1_f_at",   32'(f1_first), 32'd159);
    check("div1_f_per",  32'(f1_second - f1_first), 32'd160);

    // Frame 2 with s=1: black throughout, active region unchanged.
    s = 1'b1;
    vid = 0; draw = 0;
    for (int k = 1; k <= 320; k++) begin
      @(posedge clk);
      #1;
      if (video_on) vid++;
      if (rgb != 12'h000) draw++;
    end
    check("s1_video_clks", 32'(vid),  32'd96);
    check("s1_rgb_nonzero", 32'(draw), 32'd0);

    // Mid-frame colour change and enable drop at (5,3).
    s = 1'b0;
    step(106);
    check("drop_pos", 32'({hcount, vcount}), 32'({10'd5, 10'd3}));
    check("s_change_rgb", 32'(rgb), 32'(c_COLOR));
    en_counter = 1'b0;
    check("drop_f", 32'(f), 32'd0);
    step(1);
    check("drop_counters", 32'({hcount, vcount}), 32'd0);
    check("drop_outs", 32'({hsync, vsync, video_on, rgb}), 32'({1'b1, 1'b1, 1'b0, 12'h000}));
    f_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      if (f) f_cnt++;
    end
    check("drop_no_f", 32'(f_cnt), 32'd0);
    en_counter = 1'b1;
    step(1);
    check("restart_k1", 32'({hcount, vcount}), 32'd0);
    step(1);
    check("restart_k2", 32'({hcount, vcount}), 32'({10'd1, 10'd0}));

    // Enable dropped in the frame-done cycle.
    step(317);
    check("f_again", 32'(f), 32'd1);
    en_counter = 1'b0;
    step(1);
    check("fdrop_counters", 32'({f, hcount, vcount}), 32'd0);

    // Asynchronous reset in the sync region at (11,7).
    en_counter = 1'b1;
    step(247);
    check("pre_rst_pos",  32'({hcount, vcount}), 32'({10'd11, 10'd7}));
    check("pre_rst_sync", 32'({hsync, vsync}), 32'd0);
    #2 reset = 1'b0;
    #1;
    check("async_rst_sync", 32'({hsync, vsync}), 32'd3);
    check("async_rst_cnt",  32'({hcount, vcount, video_on}), 32'd0);
    step(1);
    reset = 1'b1;
    step(1);
    check("post_rst_k1", 32'(hcount), 32'd0);
    step(1);
    check("post_rst_k2", 32'(hcount), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
